// File: rtl/letter_scheduler.sv
// Three-slot falling-letter game sequencer: spawns LFSR letters, drops them on a
// divided tick, retires matched guesses and charges a life for each letter that lands.
module letter_scheduler #(
    parameter int unsigned TICK_DIV  = 25_000_000,
    parameter int unsigned SPAWN_GAP = 8,
    parameter int unsigned BOTTOM    = 22,
    parameter int unsigned LIVES     = 3,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] guess,
    input  logic       guess_valid,
    output logic [7:0] letter1,
    output logic [7:0] letter2,
    output logic [7:0] letter3,
    output logic [4:0] ypos1,
    output logic [4:0] ypos2,
    output logic [4:0] ypos3,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       hit,
    output logic       game_over
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam logic [4:0] HIDDEN = 5'd31;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

    state_t        state_q, state_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [SW-1:0] gap_q, gap_d;
    logic          pend_q, pend_d;
    logic [7:0]    letter_q [3];
    logic [7:0]    letter_d [3];
    logic [4:0]    ypos_q [3];
    logic [4:0]    ypos_d [3];
    logic [7:0]    score_q, score_d;
    logic [1:0]    lives_q, lives_d;
    logic          hit_q, hit_d;
    logic          over_q, over_d;

    logic          run, enter, step, wrap, spawn_due, lives_out;
    logic [2:0]    active;
    logic          found, free_found;
    logic [1:0]    sel, free_idx, misses;
    logic [4:0]    best_y;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [1:0] sat_sub2(input logic [1:0] a, input logic [1:0] b);
        return (b >= a) ? 2'd0 : a - b;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_OVER: if (start) state_d = S_PLAY;
            S_PLAY:         if (lives_out) state_d = S_OVER;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        run    = (state_q == S_PLAY);
        enter  = (state_q != S_PLAY) && start;
        over_d = (state_d == S_OVER);
    end

    always_comb begin
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        step      = run && (tick_q == TW'(TICK_DIV - 1));
        wrap      = (gap_q == SW'(SPAWN_GAP - 1));
        spawn_due = step && (wrap || pend_q);

        found  = 1'b0;
        sel    = 2'd0;
        best_y = 5'd0;
        for (int i = 0; i < 3; i++) active[i] = (ypos_q[i] != HIDDEN);
        // Deepest matching letter wins; strict compare leaves ties to the lowest index.
        for (int i = 0; i < 3; i++) begin
            if (run && guess_valid && active[i] && (letter_q[i] == guess) &&
                (!found || (ypos_q[i] > best_y))) begin
                found  = 1'b1;
                sel    = 2'(i);
                best_y = ypos_q[i];
            end
        end
        // Only slots already empty at the start of the cycle may take a spawn.
        free_found = 1'b0;
        free_idx   = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (!active[i]) begin
                free_found = 1'b1;
                free_idx   = 2'(i);
            end
        end

        tick_d  = tick_q;
        gap_d   = gap_q;
        pend_d  = pend_q;
        score_d = score_q;
        lives_d = lives_q;
        misses  = 2'd0;
        for (int i = 0; i < 3; i++) begin
            letter_d[i] = letter_q[i];
            ypos_d[i]   = ypos_q[i];
        end

        if (run) begin
            tick_d = step ? '0 : tick_q + 1'b1;
            if (step) gap_d = wrap ? '0 : gap_q + 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (found && (sel == 2'(i))) begin
                    ypos_d[i] = HIDDEN;
                end else if (step && active[i]) begin
                    if (ypos_q[i] + 5'd1 == 5'(BOTTOM)) begin
                        ypos_d[i] = HIDDEN;
                        misses    = misses + 2'd1;
                    end else begin
                        ypos_d[i] = ypos_q[i] + 5'd1;
                    end
                end
            end
            if (spawn_due) begin
                pend_d = !free_found;
                for (int i = 0; i < 3; i++) begin
                    if (free_found && (free_idx == 2'(i))) begin
                        ypos_d[i]   = 5'd0;
                        letter_d[i] = lfsr_q;
                    end
                end
            end
            if (found) score_d = sat_inc8(score_q);
            lives_d = sat_sub2(lives_q, misses);
            if (lives_d == 2'd0) begin
                for (int i = 0; i < 3; i++) ypos_d[i] = HIDDEN;
            end
        end else if (enter) begin
            tick_d      = '0;
            gap_d       = '0;
            pend_d      = 1'b0;
            score_d     = 8'd0;
            lives_d     = 2'(LIVES);
            ypos_d[0]   = 5'd0;
            letter_d[0] = lfsr_q;
            for (int i = 1; i < 3; i++) begin
                ypos_d[i]   = HIDDEN;
                letter_d[i] = 8'd0;
            end
        end

        hit_d     = found;
        lives_out = run && (lives_d == 2'd0);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lfsr_q  <= LFSR_SEED;
            tick_q  <= '0;
            gap_q   <= '0;
            pend_q  <= 1'b0;
            score_q <= 8'd0;
            lives_q <= 2'd0;
            hit_q   <= 1'b0;
            over_q  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                letter_q[i] <= 8'd0;
                ypos_q[i]   <= HIDDEN;
            end
        end else begin
            lfsr_q  <= lfsr_d;
            tick_q  <= tick_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            score_q <= score_d;
            lives_q <= lives_d;
            hit_q   <= hit_d;
            over_q  <= over_d;
            for (int i = 0; i < 3; i++) begin
                letter_q[i] <= letter_d[i];
                ypos_q[i]   <= ypos_d[i];
            end
        end
    end

    assign letter1   = letter_q[0];
    assign letter2   = letter_q[1];
    assign letter3   = letter_q[2];
    assign ypos1     = ypos_q[0];
    assign ypos2     = ypos_q[1];
    assign ypos3     = ypos_q[2];
    assign score     = score_q;
    assign lives     = lives_q;
    assign hit       = hit_q;
    assign game_over = over_q;
endmodule

// File: tb/tb_letter_scheduler.sv
// Bench for letter_scheduler: a fast-tick instance for drop/miss/coincident cases and a
// 255-cycle-tick instance whose spawns all reuse one letter, for priority and pending spawns.
module tb_letter_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, gv_a = 1'b0, start_b = 1'b0, gv_b = 1'b0;
    logic [7:0] guess_a = 8'd0, guess_b = 8'd0;
    logic [7:0] l1a, l2a, l3a, sca, l1b, l2b, l3b, scb;
    logic [4:0] y1a, y2a, y3a, y1b, y2b, y3b;
    logic [1:0] lva, lvb;
    logic       hita, goa, hitb, gob;

    letter_scheduler #(.TICK_DIV(4), .SPAWN_GAP(2), .BOTTOM(22), .LIVES(1), .LFSR_SEED(8'hA5)) dut_a (
        .clock(clk), .reset_n(rst_n), .start(start_a), .guess(guess_a), .guess_valid(gv_a),
        .letter1(l1a), .letter2(l2a), .letter3(l3a), .ypos1(y1a), .ypos2(y2a), .ypos3(y3a),
        .score(sca), .lives(lva), .hit(hita), .game_over(goa));

    letter_scheduler #(.TICK_DIV(255), .SPAWN_GAP(2), .BOTTOM(22), .LIVES(3), .LFSR_SEED(8'hA5)) dut_b (
        .clock(clk), .reset_n(rst_n), .start(start_b), .guess(guess_b), .guess_valid(gv_b),
        .letter1(l1b), .letter2(l2b), .letter3(l3b), .ypos1(y1b), .ypos2(y2b), .ypos3(y3b),
        .score(scb), .lives(lvb), .hit(hitb), .game_over(gob));

    // Reference LFSR: x^8+x^6+x^5+x^4+1, reloaded by reset, advancing every cycle.
    logic [7:0] lfsr_m;
    always @(posedge clk) lfsr_m <= !rst_n ? 8'hA5 : {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};

    typedef struct { int score; int slot; } hit_t;
    hit_t qa[$];
    hit_t qb[$];
    hit_t ha, hb;
    int checks = 0, errors = 0, ecount = 0;
    localparam int D = 255;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int ya(input int s);
        return (s == 0) ? int'(y1a) : (s == 1) ? int'(y2a) : int'(y3a);
    endfunction

    function automatic int yb(input int s);
        return (s == 0) ? int'(y1b) : (s == 1) ? int'(y2b) : int'(y3b);
    endfunction

    always begin
        @(posedge clk); #1;
        if (hita) begin
            if (qa.size() == 0) chk("a_spurious_hit", 1, 0);
            else begin
                ha = qa.pop_front();
                chk("a_hit_score", int'(sca), ha.score);
                chk("a_hit_slot_cleared", ya(ha.slot), 31);
            end
        end
    end

    always begin
        @(posedge clk); #1;
        if (hitb) begin
            if (qb.size() == 0) chk("b_spurious_hit", 1, 0);
            else begin
                hb = qb.pop_front();
                chk("b_hit_score", int'(scb), hb.score);
                chk("b_hit_slot_cleared", yb(hb.slot), 31);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            ecount++;
        end
    endtask

    task automatic go_to(input int target);
        if (target > ecount) cyc(target - ecount);
    endtask

    int na, nb;
    logic [7:0] xa, xa2, xb, xb2, xb7;

    initial begin
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        chk("idle_ypos1", y1a, 31); chk("idle_ypos2", y2a, 31); chk("idle_ypos3", y3a, 31);
        chk("idle_letter1", l1a, 0); chk("idle_letter2", l2a, 0); chk("idle_letter3", l3a, 0);
        chk("idle_score", sca, 0); chk("idle_lives", lva, 0);
        chk("idle_hit", hita, 0); chk("idle_game_over", goa, 0);
        chk("idle_b_ypos1", y1b, 31); chk("idle_b_lives", lvb, 0);

        guess_a = 8'h00; gv_a = 1'b1;
        cyc(1);
        gv_a = 1'b0;
        chk("idle_guess_hit", hita, 0); chk("idle_guess_score", sca, 0); chk("idle_guess_ypos1", y1a, 31);

        // Game 1 on A: no guesses, slot 1 lands and the only life is lost.
        xa = lfsr_m; start_a = 1'b1;
        cyc(1);
        start_a = 1'b0; na = ecount;
        chk("a_start_ypos1", y1a, 0); chk("a_start_letter1", l1a, xa);
        chk("a_start_lives", lva, 1); chk("a_start_ypos2", y2a, 31); chk("a_start_game_over", goa, 0);
        go_to(na + 3); chk("a_before_step1_ypos1", y1a, 0);
        go_to(na + 4); chk("a_step1_ypos1", y1a, 1); chk("a_step1_ypos2", y2a, 31);
        go_to(na + 7); xa2 = lfsr_m;
        go_to(na + 8); chk("a_step2_ypos1", y1a, 2); chk("a_step2_ypos2", y2a, 0); chk("a_step2_letter2", l2a, xa2);
        go_to(na + 87); chk("a_pre_miss_ypos1", y1a, 21); chk("a_pre_miss_lives", lva, 1); chk("a_pre_miss_over", goa, 0);
        go_to(na + 88);
        chk("a_miss_ypos1", y1a, 31); chk("a_miss_lives", lva, 0); chk("a_miss_game_over", goa, 1);
        chk("a_over_ypos2", y2a, 31); chk("a_over_letter1_hold", l1a, xa); chk("a_over_score", sca, 0);

        // Game 2 on A from OVER: guess lands on the step edge where slot 1 would miss.
        xa = lfsr_m; start_a = 1'b1;
        cyc(1);
        start_a = 1'b0; na = ecount;
        chk("a_restart_ypos1", y1a, 0); chk("a_restart_letter1", l1a, xa);
        chk("a_restart_lives", lva, 1); chk("a_restart_game_over", goa, 0);
        go_to(na + 87);
        guess_a = xa; gv_a = 1'b1; qa.push_back('{score: 1, slot: 0});
        cyc(1);
        gv_a = 1'b0;
        chk("a_coinc_ypos1", y1a, 31); chk("a_coinc_score", sca, 1);
        chk("a_coinc_lives", lva, 1); chk("a_coinc_game_over", goa, 0); chk("a_coinc_ypos2", y2a, 20);

        // Instance B: every step lands 255 cycles apart, so all spawns carry the same letter.
        cyc(5);
        xb = lfsr_m; start_b = 1'b1;
        cyc(1);
        start_b = 1'b0; nb = ecount;
        chk("b_start_ypos1", y1b, 0); chk("b_start_letter1", l1b, xb); chk("b_start_lives", lvb, 3);
        go_to(nb + 2*D - 1); xb2 = lfsr_m;
        go_to(nb + 2*D);
        chk("b_step2_ypos1", y1b, 2); chk("b_step2_ypos2", y2b, 0);
        chk("b_step2_letter2", l2b, xb2); chk("b_step2_ypos3", y3b, 31);
        go_to(nb + 6*D);
        chk("b_full_ypos1", y1b, 6); chk("b_full_ypos2", y2b, 4); chk("b_full_ypos3", y3b, 2);
        go_to(nb + 6*D + 10);
        guess_b = xb; gv_b = 1'b1; qb.push_back('{score: 1, slot: 0});
        cyc(1);
        gv_b = 1'b0;
        chk("b_retire1_ypos1", y1b, 31); chk("b_retire1_ypos2", y2b, 4);
        go_to(nb + 7*D - 1); xb7 = lfsr_m;
        go_to(nb + 7*D);
        chk("b_pending_ypos1", y1b, 0); chk("b_pending_letter1", l1b, xb7);
        chk("b_pending_ypos2", y2b, 5); chk("b_pending_ypos3", y3b, 3);
        go_to(nb + 7*D + 10);
        guess_b = xb; gv_b = 1'b1; qb.push_back('{score: 2, slot: 1});
        cyc(1);
        gv_b = 1'b0;
        chk("b_prio_ypos2", y2b, 31); chk("b_prio_ypos1", y1b, 0);
        chk("b_prio_ypos3", y3b, 3); chk("b_prio_score", scb, 2);
        go_to(nb + 8*D);
        chk("b_respawn_ypos1", y1b, 1); chk("b_respawn_ypos2", y2b, 0); chk("b_respawn_ypos3", y3b, 4);
        go_to(nb + 8*D + 10);
        guess_b = xb; gv_b = 1'b1;
        qb.push_back('{score: 3, slot: 2});
        qb.push_back('{score: 4, slot: 0});
        qb.push_back('{score: 5, slot: 1});
        cyc(3);
        gv_b = 1'b0;
        chk("b_b2b_ypos1", y1b, 31); chk("b_b2b_ypos2", y2b, 31); chk("b_b2b_ypos3", y3b, 31);
        chk("b_b2b_score", scb, 5);
        gv_b = 1'b1;
        cyc(1);
        gv_b = 1'b0;
        chk("b_nomatch_hit", hitb, 0); chk("b_nomatch_score", scb, 5);
        go_to(nb + 10*D);
        chk("b_step10_ypos1", y1b, 0); chk("b_step10_lives", lvb, 3); chk("b_step10_game_over", gob, 0);

        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        chk("b_reset_ypos1", y1b, 31); chk("b_reset_letter1", l1b, 0);
        chk("b_reset_score", scb, 0); chk("b_reset_lives", lvb, 0); chk("b_reset_game_over", gob, 0);
        chk("a_reset_ypos2", y2a, 31); chk("a_reset_score", sca, 0);
        cyc(3);
        chk("a_hits_outstanding", qa.size(), 0);
        chk("b_hits_outstanding", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
